// File: rtl/pwr_pkg.sv
// Shared encodings for the WFI sleep/wake controller: FSM states,
// config register addresses and CTRL bit positions.
package pwr_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } pwr_state_e;

   localparam logic [1:0] ADDR_CTRL        = 2'd0;
   localparam logic [1:0] ADDR_RELOAD      = 2'd1;
   localparam logic [1:0] ADDR_STATUS      = 2'd2;
   localparam logic [1:0] ADDR_SLEEP_COUNT = 2'd3;

   localparam int CTRL_SLEEP_EN = 0;
   localparam int CTRL_TIMER_EN = 1;
   localparam int CTRL_EXT_EN   = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, with a one-cycle
// pulse on the synchronized rising edge.
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // meta/sync form the synchronizer; prev_q is the edge-detect history
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/wfi_power_ctrl.sv
// Sleep/wake controller: parks the core on a wfi rising edge and wakes it on
// a countdown timer or the synchronized ext_wake pin. Clock gate lives above.
module wfi_power_ctrl
   import pwr_pkg::*;
#(
   parameter int                     TIMER_WIDTH    = 24,
   parameter logic [TIMER_WIDTH-1:0] DEFAULT_RELOAD = 24'd48000,
   parameter int                     WAKE_LATENCY   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wfi_i,
   input  logic        mem_stall_i,
   input  logic        ext_wake_i,
   input  logic        cfg_we_i,
   input  logic [1:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   output logic        proc_clk_en_o,
   output logic        sleeping_o,
   output logic        wake_irq_o,
   output logic [1:0]  wake_cause_o
);

   pwr_state_e             state_q;
   logic                   run_en_q;
   logic                   wake_irq_q;
   logic [1:0]             wake_cause_q;
   logic [TIMER_WIDTH-1:0] timer_q;
   logic [3:0]             wake_cnt_q;
   logic                   wfi_q;
   logic [2:0]             ctrl_q;
   logic [TIMER_WIDTH-1:0] reload_q;
   logic [31:0]            sleep_count_q;
   logic [31:0]            sleep_count_d;

   logic ext_level;
   logic ext_rise;
   logic wfi_rise;
   logic enter_sleep;
   logic timer_hit;
   logic ext_hit;
   logic count_clr;
   logic unused_wdata;

   sync_edge_detect u_ext_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (ext_wake_i),
      .level_o (ext_level),
      .rise_o  (ext_rise)
   );

   assign wfi_rise    = wfi_i & ~wfi_q;
   assign enter_sleep = (state_q == ST_DRAIN) & ~mem_stall_i;
   assign timer_hit   = (state_q == ST_SLEEP) & ctrl_q[CTRL_TIMER_EN] & (timer_q == '0);
   assign ext_hit     = (state_q == ST_SLEEP) & ctrl_q[CTRL_EXT_EN] & ext_rise;
   assign count_clr   = cfg_we_i & (cfg_addr_i == ADDR_SLEEP_COUNT);
   assign unused_wdata = ^cfg_wdata_i;

   // Power FSM with its timer, wake cause and registered enables
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         run_en_q     <= 1'b1;
         wake_irq_q   <= 1'b0;
         wake_cause_q <= 2'b00;
         timer_q      <= '0;
         wake_cnt_q   <= 4'd0;
         wfi_q        <= 1'b0;
      end else begin
         wfi_q      <= wfi_i;
         wake_irq_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (wfi_rise && ctrl_q[CTRL_SLEEP_EN]) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!mem_stall_i) begin
                  state_q      <= ST_SLEEP;
                  run_en_q     <= 1'b0;
                  timer_q      <= reload_q;
                  wake_cause_q <= 2'b00;
               end
            end
            ST_SLEEP: begin
               if (timer_hit || ext_hit) begin
                  wake_cause_q <= {ext_hit, timer_hit};
                  wake_cnt_q   <= 4'd0;
                  state_q      <= ST_WAKE;
               end else if (ctrl_q[CTRL_TIMER_EN] && (timer_q != '0)) begin
                  timer_q <= timer_q - TIMER_WIDTH'(1);
               end
            end
            ST_WAKE: begin
               if (wake_cnt_q == 4'(WAKE_LATENCY - 1)) begin
                  state_q    <= ST_RUN;
                  run_en_q   <= 1'b1;
                  wake_irq_q <= 1'b1;
               end else begin
                  wake_cnt_q <= wake_cnt_q + 4'd1;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               run_en_q <= 1'b1;
            end
         endcase
      end
   end

   // A clear and a sleep entry in the same cycle leaves the count at one
   always_comb begin
      sleep_count_d = count_clr ? 32'd0 : sleep_count_q;
      if (enter_sleep) begin
         sleep_count_d = sleep_count_d + 32'd1;
      end else begin
         sleep_count_d = sleep_count_d;
      end
   end

   // Config registers and sleep counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q        <= 3'b001;
         reload_q      <= DEFAULT_RELOAD;
         sleep_count_q <= 32'd0;
      end else begin
         if (cfg_we_i && (cfg_addr_i == ADDR_CTRL))   ctrl_q   <= cfg_wdata_i[2:0];
         if (cfg_we_i && (cfg_addr_i == ADDR_RELOAD)) reload_q <= cfg_wdata_i[TIMER_WIDTH-1:0];
         sleep_count_q <= sleep_count_d;
      end
   end

   // Read mux
   always_comb begin
      cfg_rdata_o = 32'd0;
      case (cfg_addr_i)
         ADDR_CTRL:        cfg_rdata_o = {29'd0, ctrl_q};
         ADDR_RELOAD:      cfg_rdata_o = 32'(reload_q);
         ADDR_STATUS:      cfg_rdata_o = {27'd0, ext_level, state_q, wake_cause_q};
         ADDR_SLEEP_COUNT: cfg_rdata_o = sleep_count_q;
         default:          cfg_rdata_o = 32'd0;
      endcase
   end

   assign proc_clk_en_o = run_en_q & ~mem_stall_i;
   assign sleeping_o    = (state_q != ST_RUN);
   assign wake_irq_o    = wake_irq_q;
   assign wake_cause_o  = wake_cause_q;

endmodule

// File: tb/tb_wfi_power_ctrl.sv
// Self-checking bench for wfi_power_ctrl: per-cycle vectors of inputs and
// expected post-edge outputs, queued at drive time and compared after the edge.
module tb_wfi_power_ctrl;

   typedef struct {
      logic        rst, wfi, stall, ext, we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        en, slp, irq;
      logic [1:0]  cause;
      logic [31:0] rd;
   } vec_t;

   localparam logic [1:0] R = 2'd0, D = 2'd1, S = 2'd2, W = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wfi = 1'b0, mem_stall = 1'b0, ext_wake = 1'b0, cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [31:0] cfg_wdata = 32'd0;
   logic [31:0] cfg_rdata;
   logic        proc_clk_en, sleeping, wake_irq;
   logic [1:0]  wake_cause;

   int total = 0;
   int bad = 0;
   int vec_no = 0;
   vec_t exp_q[$];
   vec_t tbl[31];

   wfi_power_ctrl dut (
      .clk_i(clk), .rst_i(rst), .wfi_i(wfi), .mem_stall_i(mem_stall),
      .ext_wake_i(ext_wake), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
      .proc_clk_en_o(proc_clk_en), .sleeping_o(sleeping),
      .wake_irq_o(wake_irq), .wake_cause_o(wake_cause)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic wf, logic st, logic ex, logic we,
                               logic [1:0] ad, logic [31:0] wd, logic en, logic slp,
                               logic irq, logic [1:0] cause, logic [31:0] rd);
      vec_t v;
      v.rst = r; v.wfi = wf; v.stall = st; v.ext = ex; v.we = we;
      v.addr = ad; v.wdata = wd; v.en = en; v.slp = slp; v.irq = irq;
      v.cause = cause; v.rd = rd;
      return v;
   endfunction

   function automatic logic [31:0] status(logic [1:0] state, logic [1:0] cause, logic lvl);
      return {27'd0, lvl, state, cause};
   endfunction

   // vector that reads STATUS with no write
   function automatic vec_t rs(logic wf, logic st, logic ex, logic en, logic slp,
                               logic irq, logic [1:0] state, logic [1:0] cause, logic lvl);
      return mk(1'b0, wf, st, ex, 1'b0, 2'd2, 32'd0, en, slp, irq, cause,
                status(state, cause, lvl));
   endfunction

   task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      @(negedge clk);
      rst = v.rst; wfi = v.wfi; mem_stall = v.stall; ext_wake = v.ext;
      cfg_we = v.we; cfg_addr = v.addr; cfg_wdata = v.wdata;
      exp_q.push_back(v);
   endtask

   // scoreboard: compare the vector driven before this edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         check("proc_clk_en", vec_no, {31'd0, proc_clk_en}, {31'd0, e.en});
         check("sleeping",    vec_no, {31'd0, sleeping},    {31'd0, e.slp});
         check("wake_irq",    vec_no, {31'd0, wake_irq},    {31'd0, e.irq});
         check("wake_cause",  vec_no, {30'd0, wake_cause},  {30'd0, e.cause});
         check("cfg_rdata",   vec_no, cfg_rdata,            e.rd);
         vec_no++;
      end
   end

   initial begin
      // timer wake, wfi held across wake, drain hold, second sleep
      tbl[0]  = mk(1, 0, 0, 0, 0, 2'd2, 32'd0, 1, 0, 0, 2'd0, status(R, 0, 0));
      tbl[1]  = mk(0, 0, 0, 0, 1, 2'd0, 32'd3, 1, 0, 0, 2'd0, 32'd3);
      tbl[2]  = mk(0, 0, 0, 0, 1, 2'd1, 32'd5, 1, 0, 0, 2'd0, 32'd5);
      tbl[3]  = mk(0, 0, 0, 0, 0, 2'd3, 32'd0, 1, 0, 0, 2'd0, 32'd0);
      tbl[4]  = rs(1, 0, 0, 1, 1, 0, D, 2'd0, 0);
      for (int i = 5; i <= 10; i++) tbl[i] = rs(1, 0, 0, 0, 1, 0, S, 2'd0, 0);
      tbl[11] = rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0);
      tbl[12] = rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0);
      tbl[13] = rs(1, 0, 0, 1, 0, 1, R, 2'd1, 0);
      tbl[14] = mk(0, 1, 0, 0, 0, 2'd3, 32'd0, 1, 0, 0, 2'd1, 32'd1);
      tbl[15] = rs(0, 0, 0, 1, 0, 0, R, 2'd1, 0);
      tbl[16] = rs(1, 0, 0, 1, 1, 0, D, 2'd1, 0);
      for (int i = 17; i <= 20; i++) tbl[i] = rs(1, 1, 0, 0, 1, 0, D, 2'd1, 0);
      for (int i = 21; i <= 26; i++) tbl[i] = rs(1, 0, 0, 0, 1, 0, S, 2'd0, 0);
      tbl[27] = rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0);
      tbl[28] = rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0);
      tbl[29] = rs(1, 0, 0, 1, 0, 1, R, 2'd1, 0);
      tbl[30] = mk(0, 1, 0, 0, 0, 2'd3, 32'd0, 1, 0, 0, 2'd1, 32'd2);

      repeat (2) @(posedge clk);
      for (int i = 0; i < 31; i++) apply(tbl[i]);

      // ext wake with timer disabled, then held-high pin gives no wake
      apply(mk(0, 0, 0, 0, 1, 2'd0, 32'd5, 1, 0, 0, 2'd1, 32'd5));
      apply(rs(1, 0, 0, 1, 1, 0, D, 2'd1, 0));
      apply(rs(1, 0, 0, 0, 1, 0, S, 2'd0, 0));
      apply(rs(1, 0, 0, 0, 1, 0, S, 2'd0, 0));
      apply(rs(1, 0, 1, 0, 1, 0, S, 2'd0, 0));
      apply(rs(1, 0, 1, 0, 1, 0, S, 2'd0, 1));
      apply(rs(1, 0, 1, 0, 1, 0, W, 2'd2, 1));
      apply(rs(1, 0, 0, 0, 1, 0, W, 2'd2, 1));
      apply(rs(1, 0, 0, 1, 0, 1, R, 2'd2, 0));
      apply(rs(0, 0, 1, 1, 0, 0, R, 2'd2, 0));
      apply(rs(0, 0, 1, 1, 0, 0, R, 2'd2, 1));
      apply(rs(1, 0, 1, 1, 1, 0, D, 2'd2, 1));
      for (int i = 0; i < 4; i++) apply(rs(1, 0, 1, 0, 1, 0, S, 2'd0, 1));

      // reset mid-sleep
      apply(mk(1, 0, 0, 0, 0, 2'd2, 32'd0, 1, 0, 0, 2'd0, status(R, 0, 0)));
      apply(mk(0, 0, 0, 0, 0, 2'd0, 32'd0, 1, 0, 0, 2'd0, 32'd1));
      apply(mk(0, 0, 0, 0, 0, 2'd1, 32'd0, 1, 0, 0, 2'd0, 32'd48000));
      apply(mk(0, 0, 0, 0, 0, 2'd3, 32'd0, 1, 0, 0, 2'd0, 32'd0));

      // timer hit and synced ext edge on the same cycle
      apply(mk(0, 0, 0, 0, 1, 2'd1, 32'd2, 1, 0, 0, 2'd0, 32'd2));
      apply(mk(0, 0, 0, 0, 1, 2'd0, 32'd7, 1, 0, 0, 2'd0, 32'd7));
      apply(rs(1, 0, 0, 1, 1, 0, D, 2'd0, 0));
      apply(rs(1, 0, 0, 0, 1, 0, S, 2'd0, 0));
      apply(rs(1, 0, 1, 0, 1, 0, S, 2'd0, 0));
      apply(rs(1, 0, 1, 0, 1, 0, S, 2'd0, 1));
      apply(rs(1, 0, 1, 0, 1, 0, W, 2'd3, 1));
      apply(rs(1, 0, 0, 0, 1, 0, W, 2'd3, 1));
      apply(rs(1, 0, 0, 1, 0, 1, R, 2'd3, 0));
      apply(rs(1, 0, 0, 1, 0, 0, R, 2'd3, 0));

      // sleep_en=0 ignores wfi; RELOAD=0 sleeps one cycle; clear on entry
      apply(mk(0, 0, 0, 0, 1, 2'd1, 32'd0, 1, 0, 0, 2'd3, 32'd0));
      apply(mk(0, 0, 0, 0, 1, 2'd0, 32'd2, 1, 0, 0, 2'd3, 32'd2));
      apply(rs(1, 0, 0, 1, 0, 0, R, 2'd3, 0));
      apply(mk(0, 0, 0, 0, 1, 2'd0, 32'd3, 1, 0, 0, 2'd3, 32'd3));
      apply(rs(1, 0, 0, 1, 1, 0, D, 2'd3, 0));
      apply(mk(0, 1, 0, 0, 1, 2'd3, 32'd0, 0, 1, 0, 2'd0, 32'd1));
      apply(rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0));
      apply(rs(1, 0, 0, 0, 1, 0, W, 2'd1, 0));
      apply(rs(1, 0, 0, 1, 0, 1, R, 2'd1, 0));
      apply(rs(1, 0, 0, 1, 0, 0, R, 2'd1, 0));

      // unimplemented register bits read back as zero
      apply(mk(0, 0, 0, 0, 1, 2'd0, 32'hFFFF_FFF8, 1, 0, 0, 2'd1, 32'd0));
      apply(mk(0, 0, 0, 0, 1, 2'd1, 32'hFFFF_FFFF, 1, 0, 0, 2'd1, 32'h00FF_FFFF));
      apply(mk(0, 0, 0, 0, 1, 2'd2, 32'hFFFF_FFFF, 1, 0, 0, 2'd1, status(R, 1, 0)));

      @(negedge clk);
      cfg_we = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
